// File: rtl/divider_top_if.sv
// divider_top_if: operand/result bundle for the sequential divider.
//   ST     : start request (master -> divider)
//   Y1, Y2 : dividend and divisor, W bits (master -> divider)
//   STATE  : current divider FSM state (divider -> master)
//   Q, R   : quotient and remainder, W bits (divider -> master)
//   Done   : one-cycle pulse when Q/R are updated (divider -> master)
//   DZ     : divide-by-zero flag, present only when DIV_ZERO_FLAG_EN is defined
// The master modport is the requester side; the slave modport is the divider.
interface divider_top_if #(
    parameter int W = 5
);
    logic         ST;
    logic [W-1:0] Y1;
    logic [W-1:0] Y2;
    logic [1:0]   STATE;
    logic [W-1:0] Q;
    logic [W-1:0] R;
    logic         Done;
`ifdef DIV_ZERO_FLAG_EN
    logic         DZ;

    modport master (output ST, Y1, Y2, input STATE, Q, R, Done, DZ);
    modport slave  (input ST, Y1, Y2, output STATE, Q, R, Done, DZ);
`else
    modport master (output ST, Y1, Y2, input STATE, Q, R, Done);
    modport slave  (input ST, Y1, Y2, output STATE, Q, R, Done);
`endif
endinterface

// File: rtl/divider_top.sv
// divider_top: sequential restoring (shift-subtract) unsigned divider.
//   CLK : clock, all state changes on the rising edge
//   RST : synchronous active-high reset, overrides any operation in flight
//   bus : divider_top_if.slave
//         ST starts a division when the FSM is IDLE; Y1/Y2 are captured in LOAD;
//         Q/R/Done are registered and update together one cycle after the FSM
//         reaches DONE, giving a start-to-Done latency of W+2 cycles.
// Optional build macro DIV_ZERO_FLAG_EN: adds bus.DZ and forces Q=R=0 for a
// zero divisor. Without it a zero divisor yields Q=all ones, R=dividend.
module divider_top #(
    parameter int W = 5
) (
    input  logic        CLK,
    input  logic        RST,
    divider_top_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int            CW       = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(W);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    state_t        state_r;
    state_t        state_next_s;
    logic [CW-1:0] cnt_r;
    logic [W-1:0]  a_r;      // partial remainder
    logic [W-1:0]  d_r;      // dividend being shifted out / quotient shifted in
    logic [W-1:0]  b_r;      // latched divisor
    logic [W-1:0]  q_r;
    logic [W-1:0]  r_r;
    logic          done_r;
`ifdef DIV_ZERO_FLAG_EN
    logic          dz_r;
`endif

    logic [W:0]    shifted_s;  // {A,D} shifted left, upper W+1 bits
    logic [W-1:0]  diff_s;
    logic          ge_s;

    // Trial subtraction for one restoring step. The compare is W+1 bits wide so
    // the bit shifted out of A is not lost; when it succeeds the difference is
    // below 2^W (or equals the shifted value for a zero divisor), so W bits hold it.
    always_comb begin
        shifted_s = {a_r, d_r[W-1]};
        ge_s      = (shifted_s >= {1'b0, b_r});
        diff_s    = shifted_s[W-1:0] - b_r;
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; SHIFT exits on the step that sees the counter at one.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.ST) begin
                    state_next_s = LOAD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD: begin
                state_next_s = SHIFT;
            end
            SHIFT: begin
                if (cnt_r == CNT_ONE) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Datapath: operand capture in LOAD, one restoring step per SHIFT cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_r   <= '0;
            d_r   <= '0;
            b_r   <= '0;
            cnt_r <= CNT_ZERO;
        end else begin
            case (state_r)
                LOAD: begin
                    a_r   <= '0;
                    d_r   <= bus.Y1;
                    b_r   <= bus.Y2;
                    cnt_r <= CNT_INIT;
                end
                SHIFT: begin
                    if (ge_s) begin
                        a_r <= diff_s;
                        d_r <= {d_r[W-2:0], 1'b1};
                    end else begin
                        a_r <= shifted_s[W-1:0];
                        d_r <= {d_r[W-2:0], 1'b0};
                    end
                    cnt_r <= cnt_r - CNT_ONE;
                end
                default: begin
                    a_r   <= a_r;
                    d_r   <= d_r;
                    b_r   <= b_r;
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Result registers: Q/R/Done update together from DONE and hold otherwise.
    always_ff @(posedge CLK) begin
        if (RST) begin
            q_r    <= '0;
            r_r    <= '0;
            done_r <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
            dz_r   <= 1'b0;
`endif
        end else begin
            done_r <= (state_r == DONE);
            if (state_r == DONE) begin
`ifdef DIV_ZERO_FLAG_EN
                if (b_r == '0) begin
                    q_r  <= '0;
                    r_r  <= '0;
                    dz_r <= 1'b1;
                end else begin
                    q_r  <= d_r;
                    r_r  <= a_r;
                    dz_r <= 1'b0;
                end
`else
                q_r <= d_r;
                r_r <= a_r;
`endif
            end else begin
                q_r <= q_r;
                r_r <= r_r;
            end
        end
    end

    assign bus.STATE = state_r;
    assign bus.Q     = q_r;
    assign bus.R     = r_r;
    assign bus.Done  = done_r;
`ifdef DIV_ZERO_FLAG_EN
    assign bus.DZ    = dz_r;
`endif

endmodule

// File: tb/tb_divider_top.sv
// tb_divider_top: directed self-checking bench for divider_top.
// Expected results come from an arithmetic model (/ and %) pushed to a
// scoreboard queue at start and popped when Done is observed.
module tb_divider_top;

    localparam int W = 5;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    logic CLK = 1'b0;
    logic RST;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    int   st_log[0:31];
    logic [W-1:0] last_q;
    logic [W-1:0] last_r;

    always #5 CLK = ~CLK;

    divider_top_if #(.W(W)) ifc ();

    divider_top #(.W(W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (ifc.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] y1, input logic [W-1:0] y2);
        exp_t e;
        if (y2 == '0) begin
`ifdef DIV_ZERO_FLAG_EN
            e.q  = '0;
            e.r  = '0;
            e.dz = 1'b1;
`else
            e.q  = '1;
            e.r  = y1;
            e.dz = 1'b0;
`endif
        end else begin
            e.q  = y1 / y2;
            e.r  = y1 % y2;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Drive a one-cycle start; returns #1 after the edge that samples it.
    task automatic start(input logic [W-1:0] y1, input logic [W-1:0] y2);
        @(negedge CLK);
        ifc.ST = 1'b1;
        ifc.Y1 = y1;
        ifc.Y2 = y2;
        sb.push_back(model(y1, y2));
        @(posedge CLK);
        #1;
        ifc.ST = 1'b0;
        check("state_load", 32'(ifc.STATE), 32'd1);
    endtask

    // Wait (bounded) for Done, checking Q/R hold their previous result meanwhile.
    // With disturb set, ST and new operands are driven during SHIFT.
    task automatic finish_op(input string tag, input bit disturb);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (cyc < 30) begin
            @(posedge CLK);
            #1;
            cyc++;
            st_log[cyc] = int'(ifc.STATE);
            if (ifc.Done === 1'b1) break;
            check({tag, "_q_hold"}, 32'(ifc.Q), 32'(last_q));
            check({tag, "_r_hold"}, 32'(ifc.R), 32'(last_r));
            if (disturb && cyc == 2) begin
                ifc.ST = 1'b1;
                ifc.Y1 = 5'd31;
                ifc.Y2 = 5'd1;
            end
            if (disturb && cyc == 5) begin
                ifc.ST = 1'b0;
            end
        end
        check({tag, "_latency"}, 32'(cyc), 32'(W + 2));
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sb: observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_q"}, 32'(ifc.Q), 32'(e.q));
            check({tag, "_r"}, 32'(ifc.R), 32'(e.r));
`ifdef DIV_ZERO_FLAG_EN
            check({tag, "_dz"}, 32'(ifc.DZ), 32'(e.dz));
`endif
            last_q = e.q;
            last_r = e.r;
        end
        @(posedge CLK);
        #1;
        check({tag, "_done_width"}, 32'(ifc.Done), 32'd0);
    endtask

    initial begin
        int   exp_walk[1:7];
        logic saw_done;
        exp_walk = '{2, 2, 2, 2, 2, 3, 0};
        last_q   = '0;
        last_r   = '0;
        RST      = 1'b1;
        ifc.ST   = 1'b0;
        ifc.Y1   = '0;
        ifc.Y2   = '0;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        check("rst_state", 32'(ifc.STATE), 32'd0);
        check("rst_q", 32'(ifc.Q), 32'd0);
        check("rst_r", 32'(ifc.R), 32'd0);
        check("rst_done", 32'(ifc.Done), 32'd0);
`ifdef DIV_ZERO_FLAG_EN
        check("rst_dz", 32'(ifc.DZ), 32'd0);
`endif
        RST = 1'b0;

        // 13/4 with state walk
        start(5'd13, 5'd4);
        finish_op("d13_4", 1'b0);
        for (int i = 1; i <= 7; i++) begin
            check($sformatf("walk_%0d", i), 32'(st_log[i]), 32'(exp_walk[i]));
        end

        // Previous result held until DONE, then several operand patterns
        start(5'd6, 5'd4);
        finish_op("d6_4", 1'b0);
        start(5'd31, 5'd1);
        finish_op("d31_1", 1'b0);
        start(5'd5, 5'd7);
        finish_op("d5_7", 1'b0);
        start(5'd31, 5'd31);
        finish_op("d31_31", 1'b0);
        start(5'd9, 5'd0);
        finish_op("d9_0", 1'b0);

        // ST and operand changes during SHIFT are ignored
        start(5'd13, 5'd4);
        finish_op("dist", 1'b1);
        check("dist_no_restart", 32'(ifc.STATE), 32'd0);

        // ST held high: back-to-back operations
        @(negedge CLK);
        ifc.ST = 1'b1;
        ifc.Y1 = 5'd22;
        ifc.Y2 = 5'd3;
        sb.push_back(model(5'd22, 5'd3));
        sb.push_back(model(5'd22, 5'd3));
        @(posedge CLK);
        #1;
        check("held_load1", 32'(ifc.STATE), 32'd1);
        finish_op("held1", 1'b0);
        ifc.ST = 1'b0;
        check("held_load2", 32'(ifc.STATE), 32'd1);
        finish_op("held2", 1'b0);

        // Reset during SHIFT
        start(5'd27, 5'd5);
        repeat (3) begin
            @(posedge CLK);
            #1;
        end
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check("mid_rst_state", 32'(ifc.STATE), 32'd0);
        check("mid_rst_q", 32'(ifc.Q), 32'd0);
        check("mid_rst_r", 32'(ifc.R), 32'd0);
        check("mid_rst_done", 32'(ifc.Done), 32'd0);
        RST = 1'b0;
        void'(sb.pop_back());
        last_q   = '0;
        last_r   = '0;
        saw_done = 1'b0;
        repeat (12) begin
            @(posedge CLK);
            #1;
            if (ifc.Done !== 1'b0) saw_done = 1'b1;
        end
        check("mid_rst_no_done", 32'(saw_done), 32'd0);

        // Normal operation after reset
        start(5'd20, 5'd3);
        finish_op("post_rst", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
